// File: rtl/xclk_freq_monitor.sv
`timescale 1ns/1ps
// xclk_freq_monitor: counts rising edges of an asynchronous monitored clock over a fixed
// gate window of clk, range-checks each window and qualifies the result with PLL lock.
module xclk_freq_monitor #(
   parameter int GATE_CYCLES    = 50000,
   parameter int CNT_W          = 20,
   parameter int EXP_COUNT      = 24000,
   parameter int TOL            = 240,
   parameter int STABLE_WINDOWS = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             meas_clk,
   input  logic             pll_locked,
   input  logic             err_clear,
   output logic [CNT_W-1:0] freq_count,
   output logic             count_valid,
   output logic             in_range,
   output logic             clk_good,
   output logic             err_sticky
);

   localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int GOOD_W = $clog2(STABLE_WINDOWS + 1);
   localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W:0]    EXP_EXT   = (CNT_W+1)'(EXP_COUNT);
   localparam logic [CNT_W:0]    TOL_EXT   = (CNT_W+1)'(TOL);
   localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(STABLE_WINDOWS);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, EVAL} state_t;

   state_t              state;
   state_t              state_next;
   logic                meas_s1, meas_s2, meas_s3;
   logic                lock_s1, lock_s;
   logic                meas_edge;
   logic [CNT_W-1:0]    edge_cnt;
   logic [GATE_W-1:0]   gate_cnt;
   logic [GOOD_W-1:0]   good_cnt;
   logic [GOOD_W-1:0]   good_cnt_next;
   logic                load_cnt;
   logic                count_en;
   logic                do_eval;
   logic                abort;
   logic                clr_good;
   logic [CNT_W:0]      edge_ext;
   logic [CNT_W:0]      diff;
   logic                range_ok;
   logic                err_set;

   // meas_clk is treated as data: two flops for metastability, a third for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meas_s1 <= 1'b0;
         meas_s2 <= 1'b0;
         meas_s3 <= 1'b0;
         lock_s1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         meas_s1 <= meas_clk;
         meas_s2 <= meas_s1;
         meas_s3 <= meas_s2;
         lock_s1 <= pll_locked;
         lock_s  <= lock_s1;
      end
   end

   assign meas_edge = meas_s2 & ~meas_s3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = ARM;
            ARM:     if (lock_s) state_next = MEASURE;
            MEASURE: begin
               if (!lock_s)               state_next = ARM;
               else if (gate_cnt == '0)   state_next = EVAL;
            end
            EVAL:    state_next = lock_s ? MEASURE : ARM;
            default: state_next = IDLE;
         endcase
      end
   end

   // EVAL reloads the counters itself so back-to-back windows lose only that one cycle
   always_comb begin
      load_cnt = 1'b0;
      count_en = 1'b0;
      do_eval  = 1'b0;
      abort    = 1'b0;
      if (enable) begin
         case (state)
            ARM:     load_cnt = 1'b1;
            MEASURE: begin
               if (lock_s) count_en = 1'b1;
               else        abort    = 1'b1;
            end
            EVAL: begin
               if (lock_s) begin
                  do_eval  = 1'b1;
                  load_cnt = 1'b1;
               end else begin
                  abort    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign clr_good = ~enable | abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cnt <= '0;
         gate_cnt <= '0;
      end else if (load_cnt) begin
         edge_cnt <= '0;
         gate_cnt <= GATE_LOAD;
      end else if (count_en) begin
         if (meas_edge && (edge_cnt != '1)) edge_cnt <= edge_cnt + CNT_W'(1);
         if (gate_cnt != '0)                gate_cnt <= gate_cnt - GATE_W'(1);
      end
   end

   // One extra bit keeps the absolute difference exact across the whole counter range
   always_comb begin
      edge_ext = {1'b0, edge_cnt};
      diff     = (edge_ext >= EXP_EXT) ? (edge_ext - EXP_EXT) : (EXP_EXT - edge_ext);
      range_ok = (diff <= TOL_EXT);
   end

   always_comb begin
      good_cnt_next = good_cnt;
      if (clr_good) begin
         good_cnt_next = '0;
      end else if (do_eval) begin
         if (!range_ok)                good_cnt_next = '0;
         else if (good_cnt != GOOD_MAX) good_cnt_next = good_cnt + GOOD_W'(1);
      end
   end

   assign err_set = clk_good & (~lock_s | (do_eval & ~range_ok));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freq_count  <= '0;
         count_valid <= 1'b0;
         in_range    <= 1'b0;
         good_cnt    <= '0;
         clk_good    <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         count_valid <= do_eval;
         if (do_eval) begin
            freq_count <= edge_cnt;
            in_range   <= range_ok;
         end
         good_cnt <= good_cnt_next;
         clk_good <= (good_cnt_next == GOOD_MAX);
         if (err_set)        err_sticky <= 1'b1;
         else if (err_clear) err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xclk_freq_monitor.sv
`timescale 1ns/1ps
// Directed bench for xclk_freq_monitor with a 1000-cycle gate window (480 edges expected).
module tb_xclk_freq_monitor;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        meas_clk;
   logic        pll_locked;
   logic        err_clear;
   logic [19:0] freq_count;
   logic        count_valid;
   logic        in_range;
   logic        clk_good;
   logic        err_sticky;

   int      err_cnt   = 0;
   int      check_cnt = 0;
   logic    meas_run  = 1'b1;
   realtime meas_half = 20.833;

   xclk_freq_monitor #(
      .GATE_CYCLES(1000),
      .CNT_W(20),
      .EXP_COUNT(480),
      .TOL(5),
      .STABLE_WINDOWS(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .meas_clk(meas_clk),
      .pll_locked(pll_locked),
      .err_clear(err_clear),
      .freq_count(freq_count),
      .count_valid(count_valid),
      .in_range(in_range),
      .clk_good(clk_good),
      .err_sticky(err_sticky)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Monitored clock: 24 MHz at half period 20.833 ns, 20 MHz at 25 ns, held low when stopped
   initial begin
      meas_clk = 1'b0;
      forever begin
         if (meas_run) #(meas_half) meas_clk = ~meas_clk;
         else begin
            meas_clk = 1'b0;
            #1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_cnt++;
      if (observed !== expected) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic lock, input logic clr);
      enable     = en;
      pll_locked = lock;
      err_clear  = clr;
   endtask

   task automatic waitValid(input string tag, input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!count_valid && cycles < budget);
      checkOutput(tag, 32'(count_valid), 1);
   endtask

   task automatic pulseClear();
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
   endtask

   task automatic checkGoodWindow(input string tag, input int idx);
      checkOutput({tag, "_freq"}, 32'(freq_count >= 20'd475 && freq_count <= 20'd485), 1);
      checkOutput({tag, "_in_range"}, 32'(in_range), 1);
      checkOutput({tag, "_clk_good"}, 32'(clk_good), 32'(idx == 4));
   endtask

   initial begin
      int  cyc;
      logic seen;

      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      checkOutput("rst_freq_count", 32'(freq_count), 0);
      checkOutput("rst_count_valid", 32'(count_valid), 0);
      checkOutput("rst_in_range", 32'(in_range), 0);
      checkOutput("rst_clk_good", 32'(clk_good), 0);
      checkOutput("rst_err_sticky", 32'(err_sticky), 0);

      // Nominal 24 MHz: four in-range windows bring clk_good up
      reset_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitValid("t1_valid", 1100, cyc);
      checkOutput("t1_freq_first", 32'(freq_count >= 20'd479 && freq_count <= 20'd481), 1);
      checkOutput("t1_in_range_first", 32'(in_range), 1);
      checkOutput("t1_clk_good_first", 32'(clk_good), 0);
      for (int i = 2; i <= 4; i++) begin
         waitValid("t1_valid", 1100, cyc);
         checkOutput("t1_period", cyc, 1001);
         checkOutput("t1_freq", 32'(freq_count >= 20'd479 && freq_count <= 20'd481), 1);
         checkOutput("t1_in_range", 32'(in_range), 1);
         checkOutput("t1_clk_good", 32'(clk_good), 32'(i == 4));
      end
      checkOutput("t1_err_sticky", 32'(err_sticky), 0);

      // 20 MHz window after clk_good: out of range, clk_good drops, error latches
      meas_half = 25.0;
      waitValid("t2_valid", 1100, cyc);
      checkOutput("t2_period", cyc, 1001);
      checkOutput("t2_freq", 32'(freq_count >= 20'd395 && freq_count <= 20'd405), 1);
      checkOutput("t2_in_range", 32'(in_range), 0);
      checkOutput("t2_clk_good", 32'(clk_good), 0);
      checkOutput("t2_err_sticky", 32'(err_sticky), 1);
      meas_half = 20.833;
      pulseClear();
      checkOutput("t2_err_cleared", 32'(err_sticky), 0);
      for (int i = 1; i <= 4; i++) begin
         waitValid("t2_recover_valid", 1100, cyc);
         checkGoodWindow("t2_recover", i);
      end

      // err_clear coincides with an out-of-range EVAL while clk_good=1: set wins
      meas_half = 25.0;
      repeat (1000) @(posedge clk);
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      checkOutput("t5_valid_aligned", 32'(count_valid), 1);
      checkOutput("t5_in_range", 32'(in_range), 0);
      checkOutput("t5_clk_good", 32'(clk_good), 0);
      checkOutput("t5_err_set_wins", 32'(err_sticky), 1);
      meas_half = 20.833;
      pulseClear();
      checkOutput("t5_err_lone_clear", 32'(err_sticky), 0);
      for (int i = 1; i <= 4; i++) begin
         waitValid("t3_pre_valid", 1100, cyc);
         checkGoodWindow("t3_pre", i);
      end

      // Lock loss for 10 cycles mid-window aborts the window
      repeat (500) @(negedge clk);
      pll_locked = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | count_valid;
      end
      pll_locked = 1'b1;
      checkOutput("t3_clk_good_lost", 32'(clk_good), 0);
      checkOutput("t3_err_sticky", 32'(err_sticky), 1);
      repeat (500) begin
         @(negedge clk);
         seen = seen | count_valid;
      end
      checkOutput("t3_no_valid", 32'(seen), 0);
      checkOutput("t3_freq_held", 32'(freq_count >= 20'd475 && freq_count <= 20'd485), 1);
      for (int i = 1; i <= 4; i++) begin
         waitValid("t3_relock_valid", 1200, cyc);
         checkGoodWindow("t3_relock", i);
      end

      // enable=0 mid-window: IDLE, clk_good low, results and error held
      repeat (400) @(negedge clk);
      enable = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen = seen | count_valid;
      end
      checkOutput("t6_clk_good", 32'(clk_good), 0);
      checkOutput("t6_freq_held", 32'(freq_count >= 20'd475 && freq_count <= 20'd485), 1);
      checkOutput("t6_in_range_held", 32'(in_range), 1);
      checkOutput("t6_err_held", 32'(err_sticky), 1);
      repeat (1100) begin
         @(negedge clk);
         seen = seen | count_valid;
      end
      checkOutput("t6_no_valid_idle", 32'(seen), 0);

      // Static meas_clk: zero count, never good, no error
      pulseClear();
      checkOutput("t4_err_cleared", 32'(err_sticky), 0);
      meas_run = 1'b0;
      repeat (20) @(negedge clk);
      enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         waitValid("t4_valid", 1100, cyc);
         checkOutput("t4_freq_zero", 32'(freq_count), 0);
         checkOutput("t4_in_range", 32'(in_range), 0);
         checkOutput("t4_clk_good", 32'(clk_good), 0);
         checkOutput("t4_err_sticky", 32'(err_sticky), 0);
      end

      // Asynchronous reset mid-window clears everything immediately
      meas_run = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         waitValid("t6r_valid", 1100, cyc);
         checkGoodWindow("t6r", i);
      end
      repeat (300) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("t6r_freq_count", 32'(freq_count), 0);
      checkOutput("t6r_count_valid", 32'(count_valid), 0);
      checkOutput("t6r_in_range", 32'(in_range), 0);
      checkOutput("t6r_clk_good", 32'(clk_good), 0);
      checkOutput("t6r_err_sticky", 32'(err_sticky), 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
      $finish;
   end

endmodule
